gpio_cfg_sequencer: RTL and testbench



---
 rtl/gpio_cfg_pkg.sv | 28 ++
 rtl/gpio_cfg_sequencer_if.sv | 32 +++
 rtl/gpio_cfg_clkdiv.sv | 29 ++
 rtl/gpio_cfg_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_gpio_cfg_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO serial configuration sequencer.
package gpio_cfg_pkg;

    localparam int unsigned DEF_NUM_PADS = 32'd27;
    localparam int unsigned DEF_CFG_BITS = 32'd13;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LOAD     = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_e;

    // Index width that stays legal for a single-entry range.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // Cycles from the start-accept cycle to the done_o cycle.
    function automatic int unsigned seq_latency(input int unsigned pads,
                                                input int unsigned bits,
                                                input int unsigned div);
        return pads * (32'd1 + 32'd2 * bits * div) + 32'd2 * div + 32'd1;
    endfunction

endpackage

// File: rtl/gpio_cfg_sequencer_if.sv
// Control/config-read bundle between a requester and the GPIO config sequencer.
interface gpio_cfg_sequencer_if
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned NUM_PADS = DEF_NUM_PADS,
    parameter int unsigned CFG_BITS = DEF_CFG_BITS
);
    localparam int unsigned AW = addr_width(NUM_PADS);

    logic                start_i;
    logic                busy_o;
    logic                done_o;
    logic [AW-1:0]       cfg_rd_addr_o;
    logic [CFG_BITS-1:0] cfg_rd_data_i;

    modport slave (
        input  start_i,
        input  cfg_rd_data_i,
        output busy_o,
        output done_o,
        output cfg_rd_addr_o
    );

    modport master (
        output start_i,
        output cfg_rd_data_i,
        input  busy_o,
        input  done_o,
        input  cfg_rd_addr_o
    );

endinterface

// File: rtl/gpio_cfg_clkdiv.sv
// Half-period tick counter: counts modulo CLK_DIV and restarts on request.
module gpio_cfg_clkdiv #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic i_restart,
    output logic o_last
);
    localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    // Modulo counter, forced to zero whenever the sequencer changes state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt <= 8'd0;
        end else if (i_restart) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Shifts every pad's config word into the GPIO serial chain, then strobes load.
// Optional feature: define GPIO_CFG_HOLD_EN to add the hold_o pad-holdover output.
module gpio_cfg_sequencer
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned NUM_PADS = DEF_NUM_PADS,
    parameter int unsigned CFG_BITS = DEF_CFG_BITS,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    gpio_cfg_sequencer_if.slave bus,
    output logic                serial_clock_o,
    output logic                serial_data_o,
    output logic                serial_load_o
`ifdef GPIO_CFG_HOLD_EN
    ,
    output logic                hold_o
`endif
);
    localparam int unsigned AW = addr_width(NUM_PADS);
    localparam int unsigned BW = addr_width(CFG_BITS);
    localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);

    seq_state_e          r_state, w_state;
    logic [AW-1:0]       r_addr, w_addr;
    logic [BW-1:0]       r_bitcnt, w_bitcnt;
    logic [CFG_BITS-1:0] r_shreg, w_shreg;
    logic [CFG_BITS-1:0] w_shifted;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_sclk, w_sclk;
    logic                r_sdata, w_sdata;
    logic                r_sload, w_sload;
    logic                r_load_half, w_load_half;
    logic                w_tick;
    logic                w_state_chg;

    assign w_shifted   = r_shreg << 1'b1;
    assign w_state_chg = (w_state != r_state);

    gpio_cfg_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .i_restart (w_state_chg),
        .o_last    (w_tick)
    );

    // Next-state and next-output computation for the shift sequence.
    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_bitcnt    = r_bitcnt;
        w_shreg     = r_shreg;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_sclk      = r_sclk;
        w_sdata     = r_sdata;
        w_sload     = r_sload;
        w_load_half = r_load_half;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_state = ST_FETCH;
                    w_addr  = LAST_PAD;
                    w_busy  = 1'b1;
                end else begin
                    w_busy  = 1'b0;
                end
            end
            ST_FETCH: begin
                w_shreg  = bus.cfg_rd_data_i;
                w_bitcnt = LAST_BIT;
                w_sdata  = bus.cfg_rd_data_i[CFG_BITS-1];
                w_sclk   = 1'b0;
                w_state  = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (w_tick) begin
                    w_state = ST_SHIFT_HI;
                    w_sclk  = 1'b1;
                end else begin
                    w_sclk  = 1'b0;
                end
            end
            ST_SHIFT_HI: begin
                if (w_tick) begin
                    w_sclk = 1'b0;
                    if (r_bitcnt != {BW{1'b0}}) begin
                        w_bitcnt = r_bitcnt - BW'(1'b1);
                        w_shreg  = w_shifted;
                        w_sdata  = w_shifted[CFG_BITS-1];
                        w_state  = ST_SHIFT_LO;
                    end else if (r_addr != {AW{1'b0}}) begin
                        w_addr   = r_addr - AW'(1'b1);
                        w_state  = ST_FETCH;
                    end else begin
                        w_sload     = 1'b1;
                        w_load_half = 1'b0;
                        w_state     = ST_LOAD;
                    end
                end else begin
                    w_sclk = 1'b1;
                end
            end
            ST_LOAD: begin
                // The divider wraps once mid-LOAD; the half flag marks the second pass.
                if (w_tick) begin
                    if (r_load_half) begin
                        w_sload = 1'b0;
                        w_done  = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_load_half = 1'b1;
                    end
                end else begin
                    w_sload = 1'b1;
                end
            end
            ST_DONE: begin
                w_busy  = 1'b0;
                w_sload = 1'b0;
                w_sdata = 1'b0;
                w_state = ST_IDLE;
            end
            default: begin
                w_busy  = 1'b0;
                w_sclk  = 1'b0;
                w_sload = 1'b0;
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= {AW{1'b0}};
            r_bitcnt    <= {BW{1'b0}};
            r_shreg     <= {CFG_BITS{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sclk      <= 1'b0;
            r_sdata     <= 1'b0;
            r_sload     <= 1'b0;
            r_load_half <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_bitcnt    <= w_bitcnt;
            r_shreg     <= w_shreg;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_sclk      <= w_sclk;
            r_sdata     <= w_sdata;
            r_sload     <= w_sload;
            r_load_half <= w_load_half;
        end
    end

`ifdef GPIO_CFG_HOLD_EN
    logic r_hold, w_hold;
    logic r_hold_tail, w_hold_tail;

    // Hold spans the whole sequence plus DONE and one trailing IDLE cycle.
    always_comb begin
        w_hold      = r_hold;
        w_hold_tail = r_hold_tail;
        if (r_state == ST_IDLE && w_state == ST_FETCH) begin
            w_hold      = 1'b1;
            w_hold_tail = 1'b0;
        end else if (r_state == ST_DONE) begin
            w_hold_tail = 1'b1;
        end else if (r_state == ST_IDLE && r_hold_tail) begin
            w_hold      = 1'b0;
            w_hold_tail = 1'b0;
        end else begin
            w_hold      = r_hold;
        end
    end

    // Hold register update.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_hold      <= 1'b0;
            r_hold_tail <= 1'b0;
        end else begin
            r_hold      <= w_hold;
            r_hold_tail <= w_hold_tail;
        end
    end

    assign hold_o = r_hold;
`endif

    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.cfg_rd_addr_o = r_addr;
    assign serial_clock_o    = r_sclk;
    assign serial_data_o     = r_sdata;
    assign serial_load_o     = r_sload;

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Directed bench: two pads, CLK_DIV=1 and CLK_DIV=3 instances side by side.
module tb_gpio_cfg_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_cfg_sequencer_if #(.NUM_PADS(2), .CFG_BITS(13)) bus1 ();
    gpio_cfg_sequencer_if #(.NUM_PADS(2), .CFG_BITS(13)) bus3 ();

    logic sclk1, sdata1, sload1, sclk3, sdata3, sload3;
`ifdef GPIO_CFG_HOLD_EN
    logic hold1, hold3;
`endif

    assign bus1.cfg_rd_data_i = (bus1.cfg_rd_addr_o == 1'b1) ? 13'h1A5B : 13'h0F0F;
    assign bus3.cfg_rd_data_i = (bus3.cfg_rd_addr_o == 1'b1) ? 13'h1A5B : 13'h0F0F;

    gpio_cfg_sequencer #(.NUM_PADS(2), .CFG_BITS(13), .CLK_DIV(1)) dut1 (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .bus            (bus1),
        .serial_clock_o (sclk1),
        .serial_data_o  (sdata1),
        .serial_load_o  (sload1)
`ifdef GPIO_CFG_HOLD_EN
        ,
        .hold_o         (hold1)
`endif
    );

    gpio_cfg_sequencer #(.NUM_PADS(2), .CFG_BITS(13), .CLK_DIV(3)) dut3 (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .bus            (bus3),
        .serial_clock_o (sclk3),
        .serial_data_o  (sdata3),
        .serial_load_o  (sload3)
`ifdef GPIO_CFG_HOLD_EN
        ,
        .hold_o         (hold3)
`endif
    );

    int cyc = 0;
    int start_cyc = 0;
    int rise1 = 0, load1 = 0, ovl1 = 0, done1_n = 0, done1_at = -1;
    int rise3 = 0, load3 = 0, done3_n = 0, done3_at = -1, badhi3 = 0, hirun3 = 0, unstable3 = 0;
    logic [25:0] str1 = 26'd0, str3 = 26'd0;
    logic p_sclk1 = 1'b0, p_sclk3 = 1'b0, p_sdata3 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the serial chain away from the active edge.
    always @(negedge clk) begin
        p_sclk1 <= sclk1;
        p_sclk3 <= sclk3;
        p_sdata3 <= sdata3;
        if (sclk1 && !p_sclk1) begin
            rise1 <= rise1 + 1;
            str1  <= {str1[24:0], sdata1};
        end
        if (sload1) load1 <= load1 + 1;
        if (sload1 && sclk1) ovl1 <= ovl1 + 1;
        if (bus1.done_o) begin
            done1_n  <= done1_n + 1;
            done1_at <= cyc - start_cyc;
        end
        if (sclk3 && !p_sclk3) begin
            rise3 <= rise3 + 1;
            str3  <= {str3[24:0], sdata3};
        end
        if (sclk3 && p_sclk3 && (sdata3 !== p_sdata3)) unstable3 <= unstable3 + 1;
        if (sclk3) begin
            hirun3 <= hirun3 + 1;
        end else begin
            if (hirun3 != 0 && hirun3 != 3) badhi3 <= badhi3 + 1;
            hirun3 <= 0;
        end
        if (sload3) load3 <= load3 + 1;
        if (bus3.done_o) begin
            done3_n  <= done3_n + 1;
            done3_at <= cyc - start_cyc;
        end
    end

    int n_total = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [25:0] exp_stream;
        int s_load, s_done, s_rise;
        exp_stream = {13'h1A5B, 13'h0F0F};
        bus1.start_i = 1'b0;
        bus3.start_i = 1'b0;

        // Reset state.
        rst = 1'b1;
        step(3);
        check("rst_busy", {31'd0, bus1.busy_o}, 32'd0);
        check("rst_done", {31'd0, bus1.done_o}, 32'd0);
        check("rst_sclk", {31'd0, sclk1}, 32'd0);
        check("rst_sdata", {31'd0, sdata1}, 32'd0);
        check("rst_sload", {31'd0, sload1}, 32'd0);
        check("rst_addr", {31'd0, bus1.cfg_rd_addr_o}, 32'd0);
        rst = 1'b0;
        step(2);

        // Full sequence on both dividers at once.
        bus1.start_i = 1'b1;
        bus3.start_i = 1'b1;
        start_cyc = cyc;
`ifdef GPIO_CFG_HOLD_EN
        check("hold_c0", {31'd0, hold1}, 32'd0);
`endif
        step(1);
        bus1.start_i = 1'b0;
        bus3.start_i = 1'b0;
        check("busy_c1", {31'd0, bus1.busy_o}, 32'd1);
        check("addr_c1", {31'd0, bus1.cfg_rd_addr_o}, 32'd1);
`ifdef GPIO_CFG_HOLD_EN
        check("hold_c1", {31'd0, hold1}, 32'd1);
        check("hold3_c1", {31'd0, hold3}, 32'd1);
`endif
        for (int i = 0; i < 300 && done3_n == 0; i++) step(1);
        step(3);
        check("d1_rises", rise1, 32'd26);
        check("d1_stream", {6'd0, str1}, {6'd0, exp_stream});
        check("d1_load_cycles", load1, 32'd2);
        check("d1_overlap", ovl1, 32'd0);
        check("d1_done_cnt", done1_n, 32'd1);
        check("d1_done_at", done1_at, 32'd57);
        check("d3_rises", rise3, 32'd26);
        check("d3_stream", {6'd0, str3}, {6'd0, exp_stream});
        check("d3_load_cycles", load3, 32'd6);
        check("d3_hi_phase", badhi3, 32'd0);
        check("d3_data_stable", unstable3, 32'd0);
        check("d3_done_cnt", done3_n, 32'd1);
        check("d3_done_at", done3_at, 32'd165);
        check("d1_busy_end", {31'd0, bus1.busy_o}, 32'd0);
        check("d3_busy_end", {31'd0, bus3.busy_o}, 32'd0);

        // Re-pulses at cycles 5 and 57 are ignored.
        s_done = done1_n;
        bus1.start_i = 1'b1;
        start_cyc = cyc;
        step(1);
        bus1.start_i = 1'b0;
        step(4);
        bus1.start_i = 1'b1;
        step(1);
        bus1.start_i = 1'b0;
        step(51);
        check("rp_done_c57", {31'd0, bus1.done_o}, 32'd1);
        bus1.start_i = 1'b1;
        step(1);
        bus1.start_i = 1'b0;
        check("rp_busy_c58", {31'd0, bus1.busy_o}, 32'd0);
`ifdef GPIO_CFG_HOLD_EN
        check("hold_c58", {31'd0, hold1}, 32'd1);
`endif
        step(1);
`ifdef GPIO_CFG_HOLD_EN
        check("hold_c59", {31'd0, hold1}, 32'd0);
`endif
        step(20);
        check("rp_done_cnt", done1_n - s_done, 32'd1);
        check("rp_busy_idle", {31'd0, bus1.busy_o}, 32'd0);

        // Reset at cycle 20 aborts the run.
        bus1.start_i = 1'b1;
        start_cyc = cyc;
        step(1);
        bus1.start_i = 1'b0;
        step(19);
        rst = 1'b1;
        step(1);
        s_load = load1;
        s_done = done1_n;
        check("ab_busy", {31'd0, bus1.busy_o}, 32'd0);
        check("ab_done", {31'd0, bus1.done_o}, 32'd0);
        check("ab_sclk", {31'd0, sclk1}, 32'd0);
        check("ab_sdata", {31'd0, sdata1}, 32'd0);
        check("ab_sload", {31'd0, sload1}, 32'd0);
`ifdef GPIO_CFG_HOLD_EN
        check("ab_hold", {31'd0, hold1}, 32'd0);
`endif
        rst = 1'b0;
        step(80);
        check("ab_no_load", load1 - s_load, 32'd0);
        check("ab_no_done", done1_n - s_done, 32'd0);

        // A fresh start after the abort completes normally.
        s_rise = rise1;
        bus1.start_i = 1'b1;
        start_cyc = cyc;
        step(1);
        bus1.start_i = 1'b0;
        for (int i = 0; i < 200 && done1_n == s_done; i++) step(1);
        step(2);
        check("re_done_cnt", done1_n - s_done, 32'd1);
        check("re_done_at", done1_at, 32'd57);
        check("re_rises", rise1 - s_rise, 32'd26);
        check("re_load", load1 - s_load, 32'd2);
        check("re_stream", {6'd0, str1}, {6'd0, exp_stream});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
